// File: rtl/wb_prefetch_master.sv
// Wishbone read-only prefetch master feeding a first-word-fall-through FIFO.
// Define WB_PREFETCH_TIMEOUT_EN to enable the per-transfer ack timeout.
module wb_prefetch_master #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [7:0]  len,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   OCC_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [7:0]    TO_LIM  = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    STALL,
    FIN
  } state_t;

  state_t state, state_nxt;

  logic [7:0]    len_q;
  logic [7:0]    cnt;
  logic [31:0]   adr_q;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic          full;
  logic          push;
  logic          pop;
  logic          accept;
  logic          last;
  logic          timeout;
  logic          unused_bits;

  assign full   = (occ == FULL);
  assign accept = start && (state == IDLE);
  assign push   = wbm_stb_o && wbm_ack_i;
  assign pop    = out_valid && out_ready;
  assign last   = ((cnt + 8'd1) == len_q);

  assign unused_bits = ^base_addr[1:0];

`ifdef WB_PREFETCH_TIMEOUT_EN
  logic [7:0] tcnt;

  // Counts strobe cycles of the current transfer only.
  always_ff @(posedge clk) begin
    if (rst || !wbm_stb_o || wbm_ack_i) tcnt <= '0;
    else tcnt <= tcnt + 8'd1;
  end

  assign timeout = wbm_stb_o && !wbm_ack_i &&
                   (tcnt == TO_LIM - 8'd1);

  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else err <= timeout;
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TO_LIM;
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = (len == 8'd0) ? FIN : REQ;
      end
      REQ: begin
        if (timeout) state_nxt = IDLE;
        else if (full) state_nxt = STALL;
        else if (push) begin
          if (last) state_nxt = FIN;
          else if ((occ + OCC_ONE) == FULL) state_nxt = STALL;
        end
      end
      STALL: begin
        if (!full) state_nxt = REQ;
      end
      FIN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A job may enter REQ with a full FIFO; the strobe waits for space.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    wbm_cyc_o = 1'b0;
    unique case (state)
      REQ: begin
        busy      = 1'b1;
        wbm_cyc_o = !full;
      end
      STALL: busy = 1'b1;
      FIN: done = 1'b1;
      default: ;
    endcase
  end

  assign wbm_stb_o = wbm_cyc_o;
  assign wbm_we_o  = 1'b0;
  assign wbm_sel_o = 4'hF;
  assign wbm_adr_o = adr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      adr_q <= '0;
      len_q <= '0;
      cnt   <= '0;
    end else if (accept) begin
      adr_q <= {base_addr[31:2], 2'b00};
      len_q <= len;
      cnt   <= '0;
    end else if (push) begin
      adr_q <= adr_q + 32'd4;
      cnt   <= cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wbm_dat_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({push, pop})
        2'b10: occ <= occ + OCC_ONE;
        2'b01: occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase
    end
  end

  assign out_valid = (occ != '0);
  assign out_data  = mem[rd_ptr];

endmodule
